// File: rtl/seq_step_chain_pkg.sv
// Shared types and helpers for the sequential step-chain generator.
package seq_step_chain_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_NUM_CH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index width for a channel count; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_step_ctrl.sv
// Sequencer control: IDLE/RUN/DONE FSM, channel index, pass counter, done/busy.
module seq_step_ctrl
  import seq_step_chain_pkg::*;
#(
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter bit          LOOP       = 1'b0,
  parameter bit          AUTO_START = 1'b1,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned IDX_W      = idx_w(NUM_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             hold_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             wr_c_o,
  output logic             clr_c_o,
  output logic             adv_c_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] pass_cnt_o
);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             first_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] pass_q;
  logic             last_c;

  // Entering RUN happens from IDLE on start (or the first edge after reset), or from DONE when looping.
  assign clr_c_o = ((state_q == IDLE) && (start_i || (AUTO_START && first_q))) ||
                   ((state_q == DONE) && LOOP);
  assign wr_c_o  = (state_q == RUN) && !hold_i;
  assign adv_c_o = (state_q == DONE);
  assign last_c  = (idx_q == IDX_W'(NUM_CH - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      first_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= '0;
    end else begin
      first_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_c_o) begin
            state_q <= RUN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!hold_i) begin
            if (last_c) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          pass_q <= pass_q + CNT_W'(1);
          idx_q  <= '0;
          if (LOOP) begin
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign idx_o      = idx_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_cnt_o = pass_q;

endmodule

// File: rtl/seq_step_chain.sv
// Sequential-assignment generator: channel k of each pass gets base + k*STEP, one channel per clock.
module seq_step_chain
  import seq_step_chain_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned START_VAL  = 46,
  parameter int unsigned STEP       = 1,
  parameter bit          LOOP       = 1'b0,
  parameter bit          AUTO_START = 1'b1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    hold_i,
  output logic [NUM_CH*WIDTH-1:0] ch_o,
  output logic [NUM_CH-1:0]       valid_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CNT_W-1:0]        pass_cnt_o
);

  localparam int unsigned IDX_W = idx_w(NUM_CH);

  logic [IDX_W-1:0]             idx_c;
  logic                         wr_c;
  logic                         clr_c;
  logic                         adv_c;
  logic [WIDTH-1:0]             wr_val_c;
  logic [WIDTH-1:0]             base_q, base_d;
  logic [NUM_CH-1:0][WIDTH-1:0] ch_q, ch_d;
  logic [NUM_CH-1:0]            valid_q, valid_d;

  seq_step_ctrl #(
    .NUM_CH     (NUM_CH),
    .LOOP       (LOOP),
    .AUTO_START (AUTO_START),
    .CNT_W      (CNT_W),
    .IDX_W      (IDX_W)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .hold_i     (hold_i),
    .idx_o      (idx_c),
    .wr_c_o     (wr_c),
    .clr_c_o    (clr_c),
    .adv_c_o    (adv_c),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .pass_cnt_o (pass_cnt_o)
  );

  assign wr_val_c = base_q + WIDTH'(32'(idx_c) * STEP);

  // Channel values persist across passes; only the valid flags are cleared on RUN entry.
  always_comb begin
    base_d  = base_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    if (clr_c) valid_d = '0;
    if (wr_c) begin
      ch_d[idx_c]    = wr_val_c;
      valid_d[idx_c] = 1'b1;
    end
    if (adv_c) base_d = base_q + WIDTH'(NUM_CH * STEP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      base_q  <= WIDTH'(START_VAL);
      ch_q    <= '0;
      valid_q <= '0;
    end else begin
      base_q  <= base_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

  assign ch_o    = ch_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_seq_step_chain.sv
// Bench for seq_step_chain: directed timing checks plus a done-time scoreboard per instance.
module tb_seq_step_chain;

  typedef struct {
    logic [31:0] ch;
    logic [3:0]  valid;
    logic [7:0]  pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance
  logic d_rst = 1'b0, d_start = 1'b0, d_hold = 1'b0;
  logic [31:0] d_ch; logic [3:0] d_valid; logic d_busy, d_done; logic [7:0] d_pass;
  // LOOP=1, START_VAL=250, STEP=3
  logic l_rst = 1'b0, l_start = 1'b0, l_hold = 1'b0;
  logic [31:0] l_ch; logic [3:0] l_valid; logic l_busy, l_done; logic [7:0] l_pass;
  // AUTO_START=0
  logic m_rst = 1'b0, m_start = 1'b0, m_hold = 1'b0;
  logic [31:0] m_ch; logic [3:0] m_valid; logic m_busy, m_done; logic [7:0] m_pass;

  seq_step_chain u_def (
    .clk(clk), .rst(d_rst), .start_i(d_start), .hold_i(d_hold),
    .ch_o(d_ch), .valid_o(d_valid), .busy_o(d_busy), .done_o(d_done), .pass_cnt_o(d_pass)
  );

  seq_step_chain #(.START_VAL(250), .STEP(3), .LOOP(1'b1)) u_loop (
    .clk(clk), .rst(l_rst), .start_i(l_start), .hold_i(l_hold),
    .ch_o(l_ch), .valid_o(l_valid), .busy_o(l_busy), .done_o(l_done), .pass_cnt_o(l_pass)
  );

  seq_step_chain #(.AUTO_START(1'b0)) u_man (
    .clk(clk), .rst(m_rst), .start_i(m_start), .hold_i(m_hold),
    .ch_o(m_ch), .valid_o(m_valid), .busy_o(m_busy), .done_o(m_done), .pass_cnt_o(m_pass)
  );

  exp_t dq[$];
  exp_t lq[$];
  exp_t mq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: compare the full pass result while done_o is presented.
  exp_t de, le, me;
  always @(negedge clk) begin
    if (d_done) begin
      if (dq.size() == 0) chk("d_done_unexpected", 1, 0);
      else begin
        de = dq.pop_front();
        chk("d_sb_ch", d_ch, de.ch); chk("d_sb_valid", d_valid, de.valid); chk("d_sb_pass", d_pass, de.pass);
      end
    end
    if (l_done) begin
      if (lq.size() == 0) chk("l_done_unexpected", 1, 0);
      else begin
        le = lq.pop_front();
        chk("l_sb_ch", l_ch, le.ch); chk("l_sb_valid", l_valid, le.valid); chk("l_sb_pass", l_pass, le.pass);
      end
    end
    if (m_done) begin
      if (mq.size() == 0) chk("m_done_unexpected", 1, 0);
      else begin
        me = mq.pop_front();
        chk("m_sb_ch", m_ch, me.ch); chk("m_sb_valid", m_valid, me.valid); chk("m_sb_pass", m_pass, me.pass);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick();
    chk("d_rst_ch", d_ch, 0); chk("d_rst_valid", d_valid, 0); chk("d_rst_busy", d_busy, 0);
    chk("d_rst_done", d_done, 0); chk("d_rst_pass", d_pass, 0);

    // Default pass 1, auto-started
    dq.push_back('{32'h31302F2E, 4'hF, 8'd0});
    d_rst = 1'b1;
    tick(); chk("d_e1_busy", d_busy, 1); chk("d_e1_ch", d_ch, 0);
    tick(); chk("d_e2_ch0", d_ch[7:0], 46);   chk("d_e2_valid", d_valid, 4'b0001);
    tick(); chk("d_e3_ch1", d_ch[15:8], 47);  chk("d_e3_valid", d_valid, 4'b0011);
    tick(); chk("d_e4_ch2", d_ch[23:16], 48); chk("d_e4_valid", d_valid, 4'b0111);
    tick(); chk("d_e5_ch3", d_ch[31:24], 49); chk("d_e5_valid", d_valid, 4'b1111);
    chk("d_e5_done", d_done, 1);
    tick(); chk("d_e6_done", d_done, 0); chk("d_e6_pass", d_pass, 1); chk("d_e6_busy", d_busy, 0);
    repeat (20) tick();
    chk("d_idle_ch", d_ch, 32'h31302F2E); chk("d_idle_valid", d_valid, 4'hF);
    chk("d_idle_busy", d_busy, 0); chk("d_idle_pass", d_pass, 1);

    // Pass 2 via start pulse, with a 3-cycle hold after ch1
    dq.push_back('{32'h35343332, 4'hF, 8'd1});
    d_start = 1'b1; tick(); d_start = 1'b0;
    chk("d_p2_valid_clr", d_valid, 0); chk("d_p2_ch_kept", d_ch, 32'h31302F2E); chk("d_p2_busy", d_busy, 1);
    tick(); chk("d_p2_ch0", d_ch[7:0], 50);
    tick(); chk("d_p2_ch1", d_ch[15:8], 51);
    d_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("d_hold_ch", d_ch, 32'h31303332); chk("d_hold_valid", d_valid, 4'b0011);
    end
    d_hold = 1'b0;
    tick(); chk("d_p2_ch2", d_ch[23:16], 52); chk("d_p2_valid2", d_valid, 4'b0111);
    tick(); chk("d_p2_ch3", d_ch[31:24], 53); chk("d_p2_done", d_done, 1);
    tick(); chk("d_p2_pass", d_pass, 2);

    // Pass 3 interrupted by reset after ch1
    d_start = 1'b1; tick(); d_start = 1'b0;
    tick(); chk("d_p3_ch0", d_ch[7:0], 54);
    tick(); chk("d_p3_ch1", d_ch[15:8], 55);
    d_rst = 1'b0;
    tick(); chk("d_mrst_ch", d_ch, 0); chk("d_mrst_valid", d_valid, 0); chk("d_mrst_busy", d_busy, 0);
    chk("d_mrst_done", d_done, 0); chk("d_mrst_pass", d_pass, 0);
    d_rst = 1'b1;
    dq.push_back('{32'h31302F2E, 4'hF, 8'd0});
    tick(); chk("d_r_busy", d_busy, 1);
    tick(); chk("d_r_ch0", d_ch[7:0], 46);
    tick(); tick(); tick(); chk("d_r_done", d_done, 1);
    tick(); chk("d_r_pass", d_pass, 1);

    // Looping instance with wrap-around arithmetic
    lq.push_back('{32'h0300FDFA, 4'hF, 8'd0});
    lq.push_back('{32'h0F0C0906, 4'hF, 8'd1});
    lq.push_back('{32'h1B181512, 4'hF, 8'd2});
    l_rst = 1'b1;
    n = 0;
    while (!l_done && n < 20) begin tick(); n++; end
    chk("l_first_done", l_done, 1); chk("l_first_done_lat", n, 5);
    for (int k = 1; k <= 10; k++) begin
      tick(); chk("l_done_period", l_done, (k % 5 == 0) ? 1 : 0);
    end
    chk("l_busy_loop", l_busy, 1);
    l_rst = 1'b0;
    tick();

    // Manual-start instance
    m_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); chk("m_quiet_busy", m_busy, 0);
    end
    chk("m_quiet_ch", m_ch, 0); chk("m_quiet_valid", m_valid, 0);
    mq.push_back('{32'h31302F2E, 4'hF, 8'd0});
    m_start = 1'b1; tick(); m_start = 1'b0;
    chk("m_start_busy", m_busy, 1);
    tick(); chk("m_ch0", m_ch[7:0], 46);
    m_start = 1'b1; tick(); tick(); m_start = 1'b0;
    n = 0;
    while (!m_done && n < 10) begin tick(); n++; end
    chk("m_done_seen", m_done, 1);
    m_start = 1'b1; tick(); m_start = 1'b0;
    chk("m_pass1", m_pass, 1); chk("m_idle_busy", m_busy, 0);
    repeat (5) tick();
    chk("m_pass_once", m_pass, 1); chk("m_busy_after", m_busy, 0); chk("m_valid_kept", m_valid, 4'hF);

    // Start and hold together in IDLE
    mq.push_back('{32'h35343332, 4'hF, 8'd1});
    m_start = 1'b1; m_hold = 1'b1; tick(); m_start = 1'b0;
    chk("m_sh_busy", m_busy, 1); chk("m_sh_valid", m_valid, 0);
    tick(); chk("m_sh_held", m_valid, 0);
    m_hold = 1'b0;
    tick(); chk("m_sh_ch0", m_ch[7:0], 50); chk("m_sh_valid0", m_valid, 4'b0001);
    n = 0;
    while (!m_done && n < 10) begin tick(); n++; end
    chk("m_sh_done", m_done, 1);
    tick(); chk("m_sh_pass", m_pass, 2);

    tick();
    chk("d_queue_empty", dq.size(), 0);
    chk("l_queue_empty", lq.size(), 0);
    chk("m_queue_empty", mq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
